// File: rtl/core_pll_supervisor.sv
// core_pll_supervisor
// Sequences a PLL through reset, lock acquisition and a stability window
// before releasing the downstream reset. Retries failed lock attempts and
// parks in FAULT after MAX_RETRY timeouts. Counts lock losses seen in RUN.
// All outputs are registered copies of the next-state decode.
module core_pll_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3      // legal range 1..3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       reinit,
  input  logic       clr_fault,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lost_cnt,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // One shared state timer, wide enough for the largest per-state limit.
  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW    = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    retry_q, retry_d;
  logic [7:0]    lost_q, lost_d;
  logic          locked_meta_q, locked_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          fault_q, fault_d;
  logic          restart;
  logic [1:0]    retry_inc;

  assign retry_inc = retry_q + 2'd1;

  // Two-flop synchronizer for the asynchronous lock indicator.
  // NOTE: the first flop may go metastable; only locked_s_q is ever used.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  // Next-state, timer, counter and output decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    restart = 1'b0;

    if (reinit && (state_q != ST_FAULT)) begin
      // Restart request outranks everything, including a simultaneous lock loss.
      state_d = ST_PLL_RESET;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLL_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = ST_STABILIZE;
          end else if (timer_q == LOCK_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RESET;
          end
        end
        ST_STABILIZE: begin
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 2'd0;
          end
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_PLL_RESET;
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
          end
        end
        ST_FAULT: begin
          if (clr_fault) begin
            state_d = ST_PLL_RESET;
            retry_d = 2'd0;
          end
        end
        default: state_d = ST_PLL_RESET;
      endcase
    end

    // Timer restarts on every state entry and saturates instead of wrapping.
    if (restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q != {TW{1'b1}}) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    // Outputs follow the state being entered so they change on the same edge.
    pll_rst_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, timer, counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      timer_q   <= '0;
      retry_q   <= 2'd0;
      lost_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign lost_cnt  = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_core_pll_supervisor.sv
// Directed bench for core_pll_supervisor with small parameters.
// Inputs change on the falling edge; outputs are compared on falling edges.
module tb_core_pll_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       reinit;
  logic       clr_fault;
  logic       pll_rst;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lost_cnt;
  logic [1:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  core_pll_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (3)
  ) dut (
    .refclk   (clk),
    .rst      (rst),
    .locked   (locked),
    .reinit   (reinit),
    .clr_fault(clr_fault),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .fault    (fault),
    .state    (state),
    .lost_cnt (lost_cnt),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;       // falling edges to wait before comparing
    logic       locked;
    logic       reinit;
    logic       clr_fault;
    logic [2:0] st;
    logic       pll;
    logic       sys;
    logic       flt;
    logic [1:0] retry;
    logic [7:0] lost;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input logic l, input logic r, input logic c,
                         input logic [2:0] st, input logic p, input logic s, input logic f,
                         input logic [1:0] rt, input logic [7:0] lo);
    vec_t v;
    v.n = n; v.locked = l; v.reinit = r; v.clr_fault = c;
    v.st = st; v.pll = p; v.sys = s; v.flt = f; v.retry = rt; v.lost = lo;
    vecs.push_back(v);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed compare.
  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == s) break;
    end
    check(name, state, s);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},   state,     3'd0);
    check({tag, " pll_rst"}, pll_rst,   1'b1);
    check({tag, " sys_rst"}, sys_rst,   1'b1);
    check({tag, " fault"},   fault,     1'b0);
    check({tag, " lost"},    lost_cnt,  8'd0);
    check({tag, " retry"},   retry_cnt, 2'd0);
  endtask

  // Drop lock in RUN: sys_rst must rise on exactly the third edge, then relock.
  task automatic loss_cycle(input string tag);
    locked = 1'b0;
    ticks(2);
    check({tag, " sys_rst before 3rd edge"}, sys_rst, 1'b0);
    ticks(1);
    check({tag, " sys_rst at 3rd edge"}, sys_rst, 1'b1);
    locked = 1'b1;
    wait_state(3'd3, 40, {tag, " relock to RUN"});
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; reinit = 1'b0; clr_fault = 1'b0;
    #1;
    check_reset_values("por");
    ticks(2);
    rst = 1'b0;

    // Edge numbers in the notes count rising edges after reset release.
    //       n  lk rq cf st  pl sy ft rt lost
    add_vec( 3, 0, 0, 0, 0,  1, 1, 0, 0, 0);  // E3  still holding PLL reset
    add_vec( 1, 0, 0, 0, 1,  0, 1, 0, 0, 0);  // E4  pll_rst released after 4 cycles
    add_vec(10, 0, 0, 0, 1,  0, 1, 0, 0, 0);  // E14 no lock yet
    add_vec( 2, 1, 0, 0, 1,  0, 1, 0, 0, 0);  // E16 locked rose, still in sync chain
    add_vec( 1, 1, 0, 0, 2,  0, 1, 0, 0, 0);  // E17 STABILIZE
    add_vec( 7, 1, 0, 0, 2,  0, 1, 0, 0, 0);  // E24 seven stable cycles
    add_vec( 1, 1, 0, 0, 3,  0, 0, 0, 0, 0);  // E25 RUN after eighth, 11 edges from rise
    add_vec( 2, 0, 0, 0, 3,  0, 0, 0, 0, 0);  // E27 loss still in sync chain
    add_vec( 1, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // E28 loss seen: PLL_RESET, lost=1
    add_vec( 4, 0, 0, 0, 1,  0, 1, 0, 0, 1);  // E32 back to WAIT_LOCK
    add_vec( 3, 1, 0, 0, 2,  0, 1, 0, 0, 1);  // E35 glitchy lock: STABILIZE
    add_vec( 2, 1, 0, 0, 2,  0, 1, 0, 0, 1);  // E37 high for 5 cycles
    add_vec( 2, 0, 0, 0, 2,  0, 1, 0, 0, 1);  // E39 drop not yet visible
    add_vec( 1, 0, 0, 0, 1,  0, 1, 0, 0, 1);  // E40 back to WAIT_LOCK
    add_vec( 3, 1, 0, 0, 2,  0, 1, 0, 0, 1);  // E43 STABILIZE again
    add_vec( 7, 1, 0, 0, 2,  0, 1, 0, 0, 1);  // E50 counter restarted, not yet RUN
    add_vec( 1, 1, 0, 0, 3,  0, 0, 0, 0, 1);  // E51 RUN after 8 clean cycles
    add_vec( 2, 0, 0, 0, 3,  0, 0, 0, 0, 1);  // E53 loss in sync chain
    add_vec( 1, 0, 1, 0, 0,  1, 1, 0, 0, 1);  // E54 reinit + loss: no lost increment
    add_vec( 4, 0, 0, 0, 1,  0, 1, 0, 0, 1);  // E58 WAIT_LOCK
    add_vec( 1, 0, 1, 0, 0,  1, 1, 0, 0, 1);  // E59 reinit from WAIT_LOCK
    add_vec( 3, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // E62 full reset window again
    add_vec( 1, 0, 0, 0, 1,  0, 1, 0, 0, 1);  // E63 WAIT_LOCK

    foreach (vecs[i]) begin
      locked    = vecs[i].locked;
      reinit    = vecs[i].reinit;
      clr_fault = vecs[i].clr_fault;
      ticks(vecs[i].n);
      check($sformatf("vec%0d state", i),   state,     vecs[i].st);
      check($sformatf("vec%0d pll_rst", i), pll_rst,   vecs[i].pll);
      check($sformatf("vec%0d sys_rst", i), sys_rst,   vecs[i].sys);
      check($sformatf("vec%0d fault", i),   fault,     vecs[i].flt);
      check($sformatf("vec%0d retry", i),   retry_cnt, vecs[i].retry);
      check($sformatf("vec%0d lost", i),    lost_cnt,  vecs[i].lost);
    end
    reinit = 1'b0;

    // No lock: three 100-cycle timeouts separated by 4-cycle resets.
    locked = 1'b0;
    ticks(99);  check("to1 before", state, 3'd1);
    ticks(1);   check("to1 state", state, 3'd0); check("to1 retry", retry_cnt, 2'd1);
    ticks(4);   check("to1 rewait", state, 3'd1);
    ticks(100); check("to2 state", state, 3'd0); check("to2 retry", retry_cnt, 2'd2);
    ticks(4);   check("to2 rewait", state, 3'd1);
    ticks(99);  check("to3 before", state, 3'd1);
    ticks(1);
    check("fault state", state, 3'd4);
    check("fault flag", fault, 1'b1);
    check("fault pll_rst", pll_rst, 1'b1);
    check("fault sys_rst", sys_rst, 1'b1);
    check("fault retry", retry_cnt, 2'd3);

    // reinit is ignored in FAULT.
    reinit = 1'b1; ticks(1); reinit = 1'b0;
    ticks(3);
    check("reinit in fault state", state, 3'd4);
    check("reinit in fault flag", fault, 1'b1);

    clr_fault = 1'b1; ticks(1); clr_fault = 1'b0;
    check("clr state", state, 3'd0);
    check("clr fault", fault, 1'b0);
    check("clr retry", retry_cnt, 2'd0);
    check("clr pll_rst", pll_rst, 1'b1);

    // One failed attempt, then lock: entering RUN clears retry_cnt.
    ticks(4);   check("retry run wait", state, 3'd1);
    ticks(100); check("retry run to", retry_cnt, 2'd1);
    ticks(4);
    locked = 1'b1;
    ticks(3);   check("retry kept in stabilize", retry_cnt, 2'd1);
    wait_state(3'd3, 20, "retry run reach");
    check("retry cleared in run", retry_cnt, 2'd0);
    check("run sys_rst", sys_rst, 1'b0);

    // Fresh start, then lock losses in RUN.
    rst = 1'b1; ticks(1); rst = 1'b0;
    wait_state(3'd3, 40, "loss setup run");
    for (int k = 0; k < 3; k++) loss_cycle($sformatf("loss%0d", k));
    check("lost after 3", lost_cnt, 8'd3);
    for (int k = 3; k < 300; k++) loss_cycle($sformatf("loss%0d", k));
    check("lost saturated", lost_cnt, 8'd255);

    // rst in STABILIZE clears everything without a clock edge.
    reinit = 1'b1; ticks(1); reinit = 1'b0;
    wait_state(3'd2, 20, "reach stabilize");
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    ticks(1);
    rst = 1'b0;
    wait_state(3'd3, 40, "restart after rst");
    check("restart lost", lost_cnt, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
